// File: rtl/uart_tx_sched_pkg.sv
// Shared types and helpers for the uart_tx scheduler.
// Holds the FSM state encoding and the parity-bit calculation.
package uart_tx_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WRITE,
    HOLD,
    WAIT_BUSY,
    WAIT_EMPTY,
    BREAK
  } state_t;

  // The bit that makes the frame's count of ones even (odd=0) or odd (odd=1).
  function automatic logic calc_parity(input logic [7:0] byte_val, input logic odd);
    return odd ? ~(^byte_val) : (^byte_val);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search begins one position after the previous winner.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  logic [IDX_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest pending request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    idx       = '0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = IDX_W'((int'(last_grant) + off) % NREQ);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any_req    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx among NREQ byte sources: round-robin grant, parity,
// the din/we load handshake, drain wait, and break insertion.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int BRK_W = 16
) (
  input  logic              txclk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] data,
  output logic [NREQ-1:0]   ack,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              brk_req,
  input  logic [BRK_W-1:0]  brk_len,
  output logic              brk_ack,
  output logic              tx_we,
  output logic [8:0]        tx_din,
  output logic              tx_parity,
  output logic              tx_break,
  input  logic              tx_empty,
  output logic              busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [IDX_W-1:0] winner_q, winner_d;
  logic [BRK_W-1:0] brk_cnt_q, brk_cnt_d;
  logic [NREQ-1:0]  ack_d;
  logic [8:0]       tx_din_d;
  logic             tx_we_d, tx_parity_d, tx_break_d, brk_ack_d;

  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] grant_idx;
  logic             any_req;
  logic [7:0]       sel_byte;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_req    (any_req)
  );

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NREQ; i++)
      sel_byte = sel_byte | (data[8*i +: 8] & {8{grant[i]}});
  end

  // Outputs are computed for the next state and registered alongside it.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    brk_cnt_d    = brk_cnt_q;
    ack_d        = '0;
    tx_din_d     = '0;
    tx_we_d      = 1'b0;
    tx_parity_d  = tx_parity;
    tx_break_d   = 1'b0;
    brk_ack_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (brk_req && tx_empty) begin
          state_d    = BREAK;
          brk_cnt_d  = (brk_len == '0) ? '0 : brk_len - 1'b1;
          tx_break_d = 1'b1;
          brk_ack_d  = (brk_cnt_d == '0);
        end else if (any_req && tx_empty) begin
          state_d     = SETUP;
          winner_d    = grant_idx;
          tx_din_d    = {parity_en ? calc_parity(sel_byte, parity_odd) : 1'b0, sel_byte};
          tx_parity_d = parity_en;
        end
      end
      SETUP: begin
        state_d         = WRITE;
        tx_din_d        = tx_din;
        tx_we_d         = 1'b1;
        ack_d[winner_q] = 1'b1;
        last_grant_d    = winner_q;
      end
      WRITE: begin
        state_d  = HOLD;
        tx_din_d = tx_din;
      end
      HOLD:       state_d = WAIT_BUSY;
      WAIT_BUSY:  if (!tx_empty) state_d = WAIT_EMPTY;
      WAIT_EMPTY: if (tx_empty) state_d = IDLE;
      BREAK: begin
        if (brk_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          tx_break_d = 1'b1;
          brk_cnt_d  = brk_cnt_q - 1'b1;
          brk_ack_d  = (brk_cnt_d == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NREQ - 1);
      winner_q     <= '0;
      brk_cnt_q    <= '0;
      ack          <= '0;
      brk_ack      <= 1'b0;
      tx_we        <= 1'b0;
      tx_din       <= '0;
      tx_parity    <= 1'b0;
      tx_break     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      brk_cnt_q    <= brk_cnt_d;
      ack          <= ack_d;
      brk_ack      <= brk_ack_d;
      tx_we        <= tx_we_d;
      tx_din       <= tx_din_d;
      tx_parity    <= tx_parity_d;
      tx_break     <= tx_break_d;
      busy         <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched with a simple uart_tx model
// that holds tx_empty low for a fixed frame after each write.
module tb_uart_tx_sched;

  localparam int NREQ  = 4;
  localparam int BRK_W = 16;
  localparam int FRAME = 12;

  logic              txclk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] data;
  logic [NREQ-1:0]   ack;
  logic              parity_en, parity_odd;
  logic              brk_req;
  logic [BRK_W-1:0]  brk_len;
  logic              brk_ack;
  logic              tx_we;
  logic [8:0]        tx_din;
  logic              tx_parity;
  logic              tx_break;
  logic              tx_empty = 1'b1;
  logic              busy;

  typedef struct {
    logic [1:0] idx;
    logic [8:0] din;
    logic       par;
  } exp_t;

  typedef struct {
    logic [1:0] idx;
    logic [7:0] byte_val;
    logic       pen;
    logic       podd;
    logic [8:0] din;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];
  int   total = 0;
  int   bad = 0;
  int   frame_cnt = 0;

  uart_tx_sched #(.NREQ(NREQ), .BRK_W(BRK_W)) dut (
    .txclk      (txclk),
    .reset_n    (reset_n),
    .req        (req),
    .data       (data),
    .ack        (ack),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .brk_req    (brk_req),
    .brk_len    (brk_len),
    .brk_ack    (brk_ack),
    .tx_we      (tx_we),
    .tx_din     (tx_din),
    .tx_parity  (tx_parity),
    .tx_break   (tx_break),
    .tx_empty   (tx_empty),
    .busy       (busy)
  );

  always #5 txclk = ~txclk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, want);
    end
  endtask

  // Scoreboard checks on every write, then the transmitter model advances.
  always @(negedge txclk) begin
    exp_t e;
    if (reset_n) begin
      if (tx_we) begin
        checkOutput("one_in_flight", frame_cnt, 0);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_write", 32'(tx_din), 32'h1ff);
        end else begin
          e = exp_q.pop_front();
          checkOutput("tx_din", 32'(tx_din), 32'(e.din));
          checkOutput("ack", 32'(ack), 32'(1) << e.idx);
          checkOutput("tx_parity", 32'(tx_parity), 32'(e.par));
        end
      end else if (ack != '0) begin
        checkOutput("stray_ack", 32'(ack), 0);
      end
    end
    if (reset_n && tx_we) begin
      frame_cnt = FRAME;
      tx_empty  = 1'b0;
    end else if (frame_cnt > 0) begin
      frame_cnt--;
      if (frame_cnt == 0) tx_empty = 1'b1;
    end
  end

  task automatic waitAck(input logic [1:0] idx, input int budget, input string name);
    int k = 0;
    while (!ack[idx] && k < budget) begin
      @(negedge txclk);
      k++;
    end
    if (!ack[idx]) checkOutput(name, 32'(ack), 32'(1) << idx);
  endtask

  task automatic waitIdle(input int budget);
    int k = 0;
    while (!(busy == 1'b0 && tx_empty) && k < budget) begin
      @(negedge txclk);
      k++;
    end
    if (busy) checkOutput("idle_timeout", 32'(busy), 0);
  endtask

  task automatic waitBreak(input int budget, output int len_seen, output int we_seen);
    int  k = 0;
    bit  got = 0;
    len_seen = 0;
    we_seen  = 0;
    while (k < budget) begin
      @(negedge txclk);
      k++;
      if (tx_break) len_seen++;
      if (tx_we) we_seen++;
      if (brk_ack) begin
        got = 1;
        break;
      end
    end
    if (!got) checkOutput("brk_ack_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge txclk);
    data[8*v.idx +: 8] = v.byte_val;
    parity_en  = v.pen;
    parity_odd = v.podd;
    req[v.idx] = 1'b1;
    e.idx = v.idx;
    e.din = v.din;
    e.par = v.pen;
    exp_q.push_back(e);
    waitAck(v.idx, FRAME + 20, "vec_ack_timeout");
    req[v.idx] = 1'b0;
    waitIdle(FRAME + 20);
    checkOutput("idle_din", 32'(tx_din), 0);
  endtask

  initial begin
    exp_t e;
    int   len_seen, we_seen;

    vecs[0] = '{2'd0, 8'h64, 1'b1, 1'b0, 9'h164};
    vecs[1] = '{2'd1, 8'hA5, 1'b1, 1'b0, 9'h0A5};
    vecs[2] = '{2'd2, 8'hA5, 1'b1, 1'b1, 9'h1A5};
    vecs[3] = '{2'd3, 8'h00, 1'b1, 1'b1, 9'h100};
    vecs[4] = '{2'd0, 8'hFF, 1'b1, 1'b0, 9'h0FF};
    vecs[5] = '{2'd1, 8'h01, 1'b1, 1'b1, 9'h001};
    vecs[6] = '{2'd2, 8'h7F, 1'b0, 1'b1, 9'h07F};
    vecs[7] = '{2'd3, 8'h80, 1'b1, 1'b0, 9'h180};

    reset_n = 1'b0; req = '0; data = '0; parity_en = 1'b0; parity_odd = 1'b0;
    brk_req = 1'b0; brk_len = '0;
    repeat (3) @(negedge txclk);
    checkOutput("rst_outputs", {tx_we, tx_parity, tx_break, brk_ack, busy, ack, tx_din}, 0);
    reset_n = 1'b1;

    // Cycle-by-cycle load sequence; a parity change mid-byte must not leak in.
    @(negedge txclk);
    data[7:0] = 8'h64; req[0] = 1'b1;
    e.idx = 2'd0; e.din = 9'h064; e.par = 1'b0;
    exp_q.push_back(e);
    @(negedge txclk);
    checkOutput("e1_busy", 32'(busy), 1);
    checkOutput("e1_din", 32'(tx_din), 32'h064);
    checkOutput("e1_we", 32'(tx_we), 0);
    parity_en = 1'b1;
    @(negedge txclk);
    checkOutput("e2_we", 32'(tx_we), 1);
    checkOutput("e2_din", 32'(tx_din), 32'h064);
    req[0] = 1'b0;
    @(negedge txclk);
    checkOutput("e3_we", 32'(tx_we), 0);
    checkOutput("e3_din", 32'(tx_din), 32'h064);
    @(negedge txclk);
    checkOutput("e4_din", 32'(tx_din), 0);
    checkOutput("e4_busy", 32'(busy), 1);
    parity_en = 1'b0;
    waitIdle(FRAME + 20);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // All four held: rotation starts after the last winner (requester 3).
    @(negedge txclk);
    data = 32'h13121110; parity_en = 1'b0; req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      e.idx = 2'(k % 4); e.din = 9'(32'h10 + (k % 4)); e.par = 1'b0;
      exp_q.push_back(e);
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge txclk);
      waitAck(2'(k % 4), FRAME + 20, "rr_ack_timeout");
    end
    req = '0;
    waitIdle(FRAME + 20);
    checkOutput("rr_drained", exp_q.size(), 0);

    // Break and byte requested together: break goes first.
    @(negedge txclk);
    brk_len = 16'd37; brk_req = 1'b1;
    data[23:16] = 8'h3C; req[2] = 1'b1;
    e.idx = 2'd2; e.din = 9'h03C; e.par = 1'b0;
    exp_q.push_back(e);
    waitBreak(100, len_seen, we_seen);
    brk_req = 1'b0;
    checkOutput("brk37_len", len_seen, 37);
    checkOutput("brk37_no_we", we_seen, 0);
    waitAck(2'd2, 20, "brk_byte_timeout");
    req[2] = 1'b0;
    waitIdle(FRAME + 20);

    @(negedge txclk);
    brk_len = '0; brk_req = 1'b1;
    waitBreak(20, len_seen, we_seen);
    brk_req = 1'b0;
    checkOutput("brk0_len", len_seen, 1);
    repeat (2) @(negedge txclk);
    checkOutput("brk0_done", 32'(tx_break), 0);

    // Reset while draining, then normal service resumes.
    @(negedge txclk);
    data[7:0] = 8'h99; req[0] = 1'b1;
    e.idx = 2'd0; e.din = 9'h099; e.par = 1'b0;
    exp_q.push_back(e);
    waitAck(2'd0, FRAME + 20, "pre_rst_ack_timeout");
    req[0] = 1'b0;
    repeat (6) @(negedge txclk);
    checkOutput("pre_rst_busy", 32'(busy), 1);
    #2 reset_n = 1'b0;
    #1 checkOutput("mid_rst_outputs", {tx_we, tx_parity, tx_break, brk_ack, busy, ack, tx_din}, 0);
    repeat (2) @(negedge txclk);
    reset_n = 1'b1;
    data[7:0] = 8'h55; req[0] = 1'b1;
    e.idx = 2'd0; e.din = 9'h055; e.par = 1'b0;
    exp_q.push_back(e);
    waitAck(2'd0, 2 * FRAME + 20, "post_rst_ack_timeout");
    req[0] = 1'b0;
    waitIdle(FRAME + 20);

    checkOutput("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Scheduler that shares one uart_tx transmitter among NREQ byte requesters and sequences its load handshake. It arbitrates round-robin, computes the parity bit, drives the din/we load sequence, waits for the shift register to drain, and inserts break intervals on request. It sits between the host-side byte sources and uart_tx, in the txclk domain.

## Interface

- NREQ, 4, number of requesters (2..8)
- BRK_W, 16, width of break-length counter
- txclk  in  1  16x baud clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester byte-pending flag; held until ack
- data  in  8*NREQ  requester i byte at data[8*i+7:8*i]; stable while req[i]
- ack  out  NREQ  one-cycle pulse: byte i accepted
- parity_en  in  1  include parity bit
- parity_odd  in  1  1 = odd parity, 0 = even
- brk_req  in  1  request break; held until brk_ack
- brk_len  in  BRK_W  break length in txclk cycles
- brk_ack  out  1  one-cycle pulse on last break cycle
- tx_we  out  1  uart_tx write enable
- tx_din  out  9  uart_tx data {parity bit, byte}
- tx_parity  out  1  uart_tx parity enable
- tx_break  out  1  uart_tx break
- tx_empty  in  1  uart_tx shift register empty
- busy  out  1  scheduler not in IDLE

## Operation

- States: IDLE, SETUP, WRITE, HOLD, WAIT_BUSY, WAIT_EMPTY, BREAK.
- IDLE: brk_req=1 and tx_empty=1 -> BREAK (break beats bytes); else any req and tx_empty=1 -> SETUP with winner latched; else stay.
- Arbitration: round-robin; search starts at last_grant+1 mod NREQ; last_grant updates at WRITE. Reset last_grant = NREQ-1 (req[0] first).
- SETUP (1 cycle): latch byte, parity_en, parity_odd; tx_din = {p, byte}; p = parity_en ? (parity_odd ? ~^byte : ^byte) : 0; tx_parity = latched parity_en.
- WRITE (1 cycle): tx_we=1, ack[winner]=1.
- HOLD (1 cycle): tx_we=0, tx_din held.
- WAIT_BUSY: wait tx_empty=0; then WAIT_EMPTY.
- WAIT_EMPTY: wait tx_empty=1; then IDLE. tx_din = 0 outside SETUP..HOLD.
- BREAK: latch brk_len on entry; tx_break=1 for max(brk_len,1) cycles; brk_ack on last; then IDLE.
- parity_en/parity_odd changes take effect only at next SETUP.
- req dropped by requester before ack: byte already latched in SETUP is still sent.

## Timing

- All outputs registered; reset values: ack=0, brk_ack=0, tx_we=0, tx_din=0, tx_parity=0, tx_break=0, busy=0; state IDLE.
- Edge E samples req in IDLE: E+1 SETUP (tx_din valid), E+2 tx_we=1 and ack, E+3 HOLD, E+4 WAIT_BUSY. tx_din stable from E+1 through E+3 inclusive.
- Next grant no earlier than 1 cycle after tx_empty returns high.
- Back-to-back: req[i] held after ack is treated as a new byte; round-robin still rotates.
- brk_req and req in same IDLE cycle: break first, byte afterwards.
- brk_req during a byte: taken after WAIT_EMPTY completes.
- reset_n low at any time: immediate return to reset values, in-flight byte/break abandoned, no ack.

## Structure

- Package uart_tx_sched_pkg: state enum, parity function (byte, odd) -> bit.
- Sub-module rr_arbiter (NREQ): req, last_grant -> one-hot grant; combinational.
- Bench instantiates uart_tx driven by this block.

## Test plan

- No parity, req[0] byte 0x64 -> tx_din=0x064, tx_parity=0, one tx_we pulse, ack[0] on that cycle, busy until tx_empty high.
- parity_en=1 even: 0x64 -> tx_din=0x164; 0xA5 -> tx_din=0x0A5; parity_odd=1 with 0xA5 -> tx_din=0x1A5.
- req=4'b1111 held, bytes 0x10..0x13 -> ack order 0,1,2,3,0; exactly one byte in flight at a time.
- brk_req and req[2] same cycle, brk_len=37 -> tx_break high 37 cycles, brk_ack on 37th, then byte from req[2]; brk_len=0 -> tx_break 1 cycle.
- reset_n low during WAIT_EMPTY -> all outputs 0 immediately, no ack; after release, req[0]=0x55 served normally.
